// File: rtl/bcd_scan_pkg.sv
// Shared definitions for the BCD scan sequencer.
// Contents: scan state enum, slot and divider widths, and a helper that
// clamps a requested slot number into the legal scan range.
package bcd_scan_pkg;

  localparam int SLOT_W    = 4;   // width of the BCD select code
  localparam int MAX_SLOTS = 10;  // decimal decoder outputs 0..9
  localparam int DIV_W     = 8;   // divider width, covers DIV up to 255

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // A requested slot beyond the last scanned slot restarts the scan at 0.
  function automatic logic [SLOT_W-1:0] clamp_slot(input logic [SLOT_W-1:0] val,
                                                   input int                last);
    return (int'(val) > last) ? '0 : val;
  endfunction

endpackage

// File: rtl/bcd_scan_sequencer_debounce.sv
// scan_debounce_cell: two-scan debouncer for one decoder slot.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   sample       : one-cycle strobe when this slot's return line is sampled
//   raw          : sampled line state, 1 = active
//   key          : debounced state, follows raw only after two equal samples
module scan_debounce_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  input  logic raw,
  output logic key
);

  logic prev_q, prev_d;
  logic key_q, key_d;

  // NOTE: every always_comb output gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    prev_d = prev_q;
    key_d  = key_q;
    if (sample) begin
      prev_d = raw;
      if (raw == prev_q) begin
        key_d = raw;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      key_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      key_q  <= key_d;
    end
  end

  assign key = key_q;

endmodule

// File: rtl/bcd_scan_sequencer.sv
// bcd_scan_sequencer: drives the BCD select code of a 7442-style decoder,
// dwelling DIV ce-cycles on each slot 0..LAST, samples the active-low
// return line on the last cycle of each dwell and debounces every slot
// over two consecutive scans.
// Ports:
//   clk, reset_n    : clock and asynchronous active-low reset
//   ce              : clock enable, nothing advances while low
//   run             : 1 = scan, 0 = park in IDLE (slot/divider frozen)
//   load, load_val  : jump to slot load_val (0 if beyond LAST), restart dwell
//   ret_n           : active-low return line of the selected slot
//   a, b, c, d      : registered BCD select code, a = LSB
//   slot            : current slot, equals {d,c,b,a}
//   keys            : debounced per-slot state, bits above LAST read 0
//   frame_done      : high during the ce cycle that samples slot LAST
//   busy            : high while scanning
module bcd_scan_sequencer
  import bcd_scan_pkg::*;
#(
  parameter int LAST = 9,
  parameter int DIV  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 run,
  input  logic                 load,
  input  logic [SLOT_W-1:0]    load_val,
  input  logic                 ret_n,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic [SLOT_W-1:0]    slot,
  output logic [MAX_SLOTS-1:0] keys,
  output logic                 frame_done,
  output logic                 busy
);

  scan_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sample;
  logic              dwell_end;

  assign dwell_end = (div_q == DIV_W'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    div_d      = div_q;
    sample     = 1'b0;
    frame_done = 1'b0;
    if (ce) begin
      // Load takes priority over a coincident end of dwell: the slot being
      // left is not sampled and no frame is reported.
      if (load) begin
        slot_d = clamp_slot(load_val, LAST);
        div_d  = '0;
      end else if (state_q == SCAN && run) begin
        if (dwell_end) begin
          sample     = 1'b1;
          frame_done = (slot_q == SLOT_W'(LAST));
          slot_d     = frame_done ? '0 : slot_q + SLOT_W'(1);
          div_d      = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      unique case (state_q)
        IDLE:    if (run)  state_d = SCAN;
        SCAN:    if (!run) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      div_q   <= div_d;
    end
  end

  // One debouncer per scanned slot; unscanned decoder outputs read inactive.
  for (genvar i = 0; i < MAX_SLOTS; i++) begin : g_slot
    if (i <= LAST) begin : g_cell
      scan_debounce_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (sample && (slot_q == SLOT_W'(i))),
        .raw     (~ret_n),
        .key     (keys[i])
      );
    end else begin : g_tie
      assign keys[i] = 1'b0;
    end
  end

  assign slot = slot_q;
  assign a    = slot_q[0];
  assign b    = slot_q[1];
  assign c    = slot_q[2];
  assign d    = slot_q[3];
  assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// Self-checking bench for bcd_scan_sequencer: a LAST=9/DIV=4 build and a
// LAST=5/DIV=3 build share the control inputs; each has its own return line
// derived from a "pressed keys" pattern and its own behavioural model.
module tb_bcd_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0, run = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       ret_n9 = 1'b1, ret_n5 = 1'b1;

  logic       a9, b9, c9, d9, fd9_o, busy9;
  logic [3:0] slot9;
  logic [9:0] keys9;
  logic       a5, b5, c5, d5, fd5_o, busy5;
  logic [3:0] slot5;
  logic [9:0] keys5;

  bcd_scan_sequencer #(.LAST(9), .DIV(4)) dut9 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .run(run), .load(load),
    .load_val(load_val), .ret_n(ret_n9), .a(a9), .b(b9), .c(c9), .d(d9),
    .slot(slot9), .keys(keys9), .frame_done(fd9_o), .busy(busy9)
  );

  bcd_scan_sequencer #(.LAST(5), .DIV(3)) dut5 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .run(run), .load(load),
    .load_val(load_val), .ret_n(ret_n5), .a(a5), .b(b5), .c(c5), .d(d5),
    .slot(slot5), .keys(keys5), .frame_done(fd5_o), .busy(busy5)
  );

  always #5 clk = ~clk;

  // Behavioural model: scanning flag, slot number, dwell position and
  // per-slot last-sample / debounced-key bits.
  typedef struct {
    bit       scan;
    int       slot;
    int       dv;
    bit [9:0] prev;
    bit [9:0] key;
  } mdl_t;

  mdl_t     m9, m5;
  bit [9:0] press9 = '0, press5 = '0;
  bit       fd9, fd5;
  int       total = 0;
  int       bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic mdl_t m_reset();
    mdl_t r;
    r.scan = 1'b0; r.slot = 0; r.dv = 0; r.prev = '0; r.key = '0;
    return r;
  endfunction

  // One ce-qualified step of the scan rules.
  task automatic m_eval(input mdl_t m, input int last, input int dvn,
                        input bit ce_i, input bit run_i, input bit ld_i,
                        input int lv, input bit raw,
                        output mdl_t n, output bit fd);
    n  = m;
    fd = 1'b0;
    if (!ce_i) return;
    if (ld_i) begin
      n.slot = (lv > last) ? 0 : lv;
      n.dv   = 0;
    end else if (m.scan && run_i) begin
      if (m.dv == dvn - 1) begin
        if (raw == m.prev[m.slot]) n.key[m.slot] = raw;
        n.prev[m.slot] = raw;
        fd     = (m.slot == last);
        n.slot = (m.slot == last) ? 0 : m.slot + 1;
        n.dv   = 0;
      end else begin
        n.dv = m.dv + 1;
      end
    end
    n.scan = run_i;
  endtask

  task automatic check_state();
    check("slot9", slot9, m9.slot);
    check("abcd9", {d9, c9, b9, a9}, m9.slot);
    check("keys9", keys9, m9.key);
    check("busy9", busy9, m9.scan);
    check("slot5", slot5, m5.slot);
    check("abcd5", {d5, c5, b5, a5}, m5.slot);
    check("keys5", keys5, m5.key);
    check("busy5", busy5, m5.scan);
    check("keys5_hi", keys5[9:6], 4'h0);
  endtask

  // Called at posedge+1 with inputs already set; ends at the next posedge+1.
  task automatic tick();
    mdl_t n9, n5;
    ret_n9 = !press9[m9.slot];
    ret_n5 = !press5[m5.slot];
    m_eval(m9, 9, 4, ce, run, load, int'(load_val), press9[m9.slot], n9, fd9);
    m_eval(m5, 5, 3, ce, run, load, int'(load_val), press5[m5.slot], n5, fd5);
    @(negedge clk);
    check("frame_done9", fd9_o, fd9);
    check("frame_done5", fd5_o, fd5);
    @(posedge clk);
    #1;
    m9 = n9;
    m5 = n5;
    check_state();
  endtask

  initial begin
    int       nfd;
    int       guard;
    bit [9:0] ksnap;

    m9 = m_reset();
    m5 = m_reset();

    // Reset state.
    #12;
    check("rst_slot9", slot9, 4'd0);
    check("rst_keys9", keys9, 10'h000);
    check("rst_busy9", busy9, 1'b0);
    check("rst_fd9", fd9_o, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_state();

    // Idle scan with no keys: one entry cycle, then two 40-cycle frames.
    ce = 1'b1; run = 1'b1;
    tick();
    nfd = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fd9) nfd++;
    end
    check("frames_in_80", nfd, 2);
    check("keys_quiet", keys9, 10'h000);

    // Slot 3 held active: shows after two scans, clears two scans after release.
    press9 = 10'h008;
    for (int i = 0; i < 80; i++) tick();
    check("key3_set", keys9, 10'h008);
    press9 = '0;
    for (int i = 0; i < 80; i++) tick();
    check("key3_clr", keys9, 10'h000);

    // Slot 5 active for exactly one scan is filtered out.
    press9 = 10'h020;
    for (int i = 0; i < 40; i++) tick();
    press9 = '0;
    for (int i = 0; i < 80; i++) tick();
    check("glitch5", keys9, 10'h000);

    // Load on the last dwell cycle of slot 2: load wins, no sample.
    press9 = 10'h004;
    guard = 0;
    while (!(m9.slot == 2 && m9.dv == 3) && guard < 200) begin
      tick();
      guard++;
    end
    check("wait_slot2", guard < 200, 1'b1);
    load = 1'b1; load_val = 4'd7;
    tick();
    check("load7_slot", slot9, 4'd7);
    check("load7_nofd", fd9, 1'b0);
    check("load7_nosample", m9.prev[2], 1'b0);
    load_val = 4'd12;
    tick();
    check("load12_slot", slot9, 4'd0);
    load = 1'b0;
    press9 = '0;

    // Pause mid-dwell on slot 4 at div 2, then resume.
    guard = 0;
    while (!(m9.slot == 4 && m9.dv == 2) && guard < 200) begin
      tick();
      guard++;
    end
    check("wait_slot4", guard < 200, 1'b1);
    ksnap = keys9;
    run = 1'b0;
    tick();
    check("pause_busy", busy9, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("pause_slot", slot9, 4'd4);
    check("pause_keys", keys9, ksnap);
    run = 1'b1;
    tick();
    tick();
    check("resume_slot_held", slot9, 4'd4);
    tick();
    check("resume_slot_next", slot9, 4'd5);

    // Clock enable low: everything holds.
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load = 1'($urandom_range(1)); load_val = 4'($urandom_range(15));
      tick();
    end
    load = 1'b0;
    ce = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        press9 = 10'($urandom);
        press5 = 10'($urandom) & 10'h03f;
      end
      ce       = ($urandom_range(99) < 85);
      run      = ($urandom_range(99) < 95);
      load     = ($urandom_range(99) < 2);
      load_val = 4'($urandom_range(15));
      tick();
    end

    // Build up keys = 0x208, then reset asynchronously mid-cycle.
    ce = 1'b1; run = 1'b1; load = 1'b0;
    press9 = 10'h208; press5 = '0;
    for (int i = 0; i < 90; i++) tick();
    check("keys_208", keys9, 10'h208);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_keys9", keys9, 10'h000);
    check("arst_slot9", slot9, 4'd0);
    check("arst_abcd9", {d9, c9, b9, a9}, 4'd0);
    check("arst_busy9", busy9, 1'b0);
    check("arst_fd9", fd9_o, 1'b0);
    check("arst_keys5", keys5, 10'h000);
    m9 = m_reset();
    m5 = m_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
